bin2bcd_seq_ctrl: RTL

Multi-cycle binary-to-BCD converter controller using the shift-and-adjust (double-dabble) method.
One shared single-digit adjust cell is time-multiplexed across all BCD digits of a scratch register; this block holds the FSM, the counters and the start/busy/done handshake.
It sits between binary arithmetic results and display/BCD consumers, e.g. 7-segment drivers.

---
 rtl/bin2bcd_pkg.sv | 28 ++
 rtl/bin2bcd_seq_ctrl_if.sv | 21 ++
 rtl/bcd_digit_adjust.sv | 11 +
 rtl/bin2bcd_seq_ctrl.sv | 129 ++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    localparam int unsigned BCD_DIGIT_W = 4;
    localparam int unsigned ADJ_THRESH  = 5;
    localparam int unsigned ADJ_ADD     = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADJ   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Number of decimal digits required to represent 2^width-1.
    function automatic int unsigned digits_needed(input int unsigned width);
        logic [63:0] v;
        int unsigned n;
        v = (64'd1 << width) - 64'd1;
        n = 1;
        while (v >= 64'd10) begin
            v = v / 64'd10;
            n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_ctrl_if.sv
// Start/busy/done handshake and result bus of the binary-to-BCD converter.
// Optional digit_blank signal present when BIN2BCD_BLANK_EN is defined.
interface bin2bcd_seq_ctrl_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0]     digit_blank;

    modport master (output start, bin_in, input busy, done, bcd_out, digit_blank);
    modport slave  (input start, bin_in, output busy, done, bcd_out, digit_blank);
`else
    modport master (output start, bin_in, input busy, done, bcd_out);
    modport slave  (input start, bin_in, output busy, done, bcd_out);
`endif
endinterface

// File: rtl/bcd_digit_adjust.sv
// Double-dabble adjust cell: add 3 to a BCD digit when it is 5 or more.
module bcd_digit_adjust
    import bin2bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] adj_c
);

    assign adj_c = (digit >= BCD_DIGIT_W'(ADJ_THRESH)) ? digit + BCD_DIGIT_W'(ADJ_ADD) : digit;

endmodule

// File: rtl/bin2bcd_seq_ctrl.sv
// Multi-cycle double-dabble controller sharing one digit adjust cell across all digits.
// Define BIN2BCD_BLANK_EN to add the leading-zero digit_blank output.
module bin2bcd_seq_ctrl
    import bin2bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    bin2bcd_seq_ctrl_if.slave bus
);

    localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int unsigned SCR_W = BCD_W + WIDTH;
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("bin2bcd_seq_ctrl: WIDTH must be within 1..32");
    end
    if (DIGITS < digits_needed(WIDTH)) begin : g_bad_digits
        $error("bin2bcd_seq_ctrl: DIGITS too small for WIDTH");
    end

    state_t                 state, state_nxt;
    logic [SCR_W-1:0]       scratch, scratch_nxt;
    logic [CNT_W-1:0]       bit_cnt, bit_cnt_nxt;
    logic [IDX_W-1:0]       dig_idx, dig_idx_nxt;
    logic [BCD_DIGIT_W-1:0] cur_digit;
    logic [BCD_DIGIT_W-1:0] adj_digit_c;

    // Select the digit currently being adjusted.
    always_comb begin
        cur_digit = '0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (dig_idx == IDX_W'(k))
                cur_digit = scratch[WIDTH + BCD_DIGIT_W*k +: BCD_DIGIT_W];
        end
    end

    bcd_digit_adjust u_adj (
        .digit (cur_digit),
        .adj_c (adj_digit_c)
    );

    // Next state, scratch and counters.
    always_comb begin
        state_nxt   = state;
        scratch_nxt = scratch;
        bit_cnt_nxt = bit_cnt;
        dig_idx_nxt = dig_idx;
        case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (bus.start) begin
                    state_nxt   = ADJ;
                    scratch_nxt = {BCD_W'(0), bus.bin_in};
                    bit_cnt_nxt = '0;
                    dig_idx_nxt = '0;
                end
            end
            ADJ: begin
                for (int k = 0; k < int'(DIGITS); k++) begin
                    if (dig_idx == IDX_W'(k))
                        scratch_nxt[WIDTH + BCD_DIGIT_W*k +: BCD_DIGIT_W] = adj_digit_c;
                end
                if (dig_idx == IDX_W'(DIGITS - 1))
                    state_nxt = SHIFT;
                else
                    dig_idx_nxt = dig_idx + IDX_W'(1);
            end
            SHIFT: begin
                scratch_nxt = scratch << 1;
                bit_cnt_nxt = bit_cnt + CNT_W'(1);
                dig_idx_nxt = '0;
                state_nxt   = (bit_cnt == CNT_W'(WIDTH - 1)) ? DONE : ADJ;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef BIN2BCD_BLANK_EN
    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

    logic [DIGITS-1:0] blank_nxt;
    logic              zero_above;

    // A digit blanks when it and every higher digit are zero; digit 0 never blanks.
    always_comb begin
        blank_nxt  = '0;
        zero_above = 1'b1;
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            zero_above   = zero_above & (scratch_nxt[WIDTH + BCD_DIGIT_W*k +: BCD_DIGIT_W] == '0);
            blank_nxt[k] = (k != 0) && zero_above;
        end
    end
`endif

    // Registers; outputs are derived from the upcoming state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            scratch         <= '0;
            bit_cnt         <= '0;
            dig_idx         <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.bcd_out     <= '0;
`ifdef BIN2BCD_BLANK_EN
            bus.digit_blank <= BLANK_RST;
`endif
        end else begin
            state    <= state_nxt;
            scratch  <= scratch_nxt;
            bit_cnt  <= bit_cnt_nxt;
            dig_idx  <= dig_idx_nxt;
            bus.busy <= (state_nxt == ADJ) || (state_nxt == SHIFT);
            bus.done <= (state_nxt == DONE);
            if (state_nxt == DONE) begin
                bus.bcd_out     <= scratch_nxt[SCR_W-1 -: BCD_W];
`ifdef BIN2BCD_BLANK_EN
                bus.digit_blank <= blank_nxt;
`endif
            end
        end
    end

endmodule
